immediate_encode: RTL and testbench
===================================

Name: immediate_encode

Overview:
- Pipelined packer that is the inverse of the immediate generator. It takes a 32-bit immediate, an IMM_SEL type and the remaining instruction fields, and scatters the immediate bits into instruction[31:7].
- Range-checks the immediate against the decoder's extension rules, so that a legal beat decodes back to exactly the same value.
- Used by the self-test instruction builder and the debug instruction-injection path ahead of instruction memory.

Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- CLK  input  1  clock, rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  stage 1 can accept a beat.
- IMM  input  32  immediate value to encode.
- IMM_SEL  input  3  immediate type; codes from the shared encodings header.
- FIELDS  input  25  instruction[31:7] carrying rd/rs1/rs2/funct3/funct7; bits at immediate positions are ignored.
- OUT_VALID  output  1  output beat valid.
- OUT_READY  input  1  downstream accepts the beat.
- OUT  output  25  packed instruction[31:7].
- ERR  output  1  beat failed encoding checks.
- ERR_CODE  output  2  0 none, 1 out of range, 2 misaligned, 3 illegal IMM_SEL.
- ERR_COUNT  output  CNT_W  count of errored beats delivered.
- CLR_CNT  input  1  synchronous clear of ERR_COUNT.

Behaviour:
- Reset (async, RESETN=0): both stage valids, OUT_VALID, OUT, ERR, ERR_CODE and ERR_COUNT all go to 0. In-flight beats are discarded. IN_READY=1 once reset is released.
- Pipeline structure:
  - Stage 1 registers IMM, IMM_SEL and FIELDS, and computes the check result.
  - Stage 2 registers the packed OUT, ERR and ERR_CODE.
- Latency: 2 cycles from accept (IN_VALID&&IN_READY) to OUT_VALID, with no stall. Throughput is 1 beat/cycle.
- Flow control:
  - Stage advance is the standard valid/ready rule. IN_READY = !s1_valid || !OUT_VALID || OUT_READY.
  - No beat is lost or duplicated. Order is preserved.
  - OUT, ERR and ERR_CODE are held stable while OUT_VALID && !OUT_READY.
- Packing (bits not listed are copied from FIELDS):
  - U: OUT[24:5]=IMM[31:12].
  - J: OUT[24]=IMM[20], OUT[23:14]=IMM[10:1], OUT[13]=IMM[11], OUT[12:5]=IMM[19:12].
  - B: OUT[24]=IMM[12], OUT[23:18]=IMM[10:5], OUT[4:1]=IMM[4:1], OUT[0]=IMM[11].
  - S: OUT[24:18]=IMM[11:5], OUT[4:0]=IMM[4:0].
  - I_SIGNED and I_UNSIGNED: OUT[24:13]=IMM[11:0].
  - I_SHIFT: OUT[17:13]=IMM[4:0]; OUT[24:18] comes from FIELDS (funct7, e.g. for srai).
  - Illegal (unused) IMM_SEL code: OUT=FIELDS.
- Legality checks ("uniform" means all bits equal):
  - U: IMM[11:0]==0; otherwise range error.
  - J: IMM[0]==0, else misaligned; IMM[31:20] uniform.
  - B: IMM[0]==0, else misaligned; IMM[31:12] uniform.
  - S and I_SIGNED: IMM[31:11] uniform.
  - I_UNSIGNED: IMM[31:12]==0.
  - I_SHIFT: IMM[31:5]==0.
- Error priority: illegal > misaligned > range. On error, OUT is still packed from the truncated bits and ERR=1.
- Counter:
  - ERR_COUNT increments on OUT_VALID&&OUT_READY&&ERR.
  - It saturates at 2^CNT_W-1.
  - If CLR_CNT coincides with an increment, CLR_CNT wins and the result is 0.
- Invariant: for every legal beat, the immediate generator applied to OUT with the same IMM_SEL returns IMM exactly.

Decomposition:
- The ERR_CODE constants (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_SEL) go into the shared encodings header alongside the existing IMM_SEL codes. No new IMM_SEL codes are introduced.
- One combinational sub-module, imm_range_check, takes (IMM, IMM_SEL) and returns (err, err_code). It is instantiated in stage 1.
- Packing and handshake logic stay in the top module.

Test Plan:
- Negative I-type: I_SIGNED, IMM=0xFFFFF800, FIELDS=0 → two cycles later OUT=0x1000000 (OUT[24:13]=0x800), ERR=0. Decoding the result returns 0xFFFFF800.
- J-type misalignment: J, IMM=0x00000801 → ERR=1, ERR_CODE=2.
- Range errors:
  - B, IMM=0x00001000 → ERR_CODE=1.
  - B, IMM=0xFFFFF000 → OUT[24]=1, OUT[0]=0, all other immediate bits 0, ERR=0.
- Backpressure: 4 back-to-back legal beats with OUT_READY=0 for 3 cycles → IN_READY falls after 2 beats are held. All 4 beats then emerge in order with correct OUT, and OUT stays stable while stalled.
- Illegal select and counter: unused IMM_SEL code, FIELDS=0x1ABCDEF → OUT=0x1ABCDEF, ERR_CODE=3.
  - 300 errored beats → ERR_COUNT=255.
  - CLR_CNT asserted together with an errored handshake → ERR_COUNT=0.
- Reset mid-stream: RESETN=0 asynchronously with 2 beats in flight → OUT_VALID=0 and ERR_COUNT=0 before the next edge. After release, IN_READY=1 and the first new beat appears 2 cycles after accept.

Source files
------------

// File: rtl/immediate_encode_pkg.sv
// Shared encodings for the immediate packer: IMM_SEL codes and error codes.
package immediate_encode_pkg;

  localparam logic [2:0] IMM_I_SIGNED   = 3'd0;
  localparam logic [2:0] IMM_I_UNSIGNED = 3'd1;
  localparam logic [2:0] IMM_I_SHIFT    = 3'd2;
  localparam logic [2:0] IMM_S          = 3'd3;
  localparam logic [2:0] IMM_B          = 3'd4;
  localparam logic [2:0] IMM_U          = 3'd5;
  localparam logic [2:0] IMM_J          = 3'd6;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_SEL   = 2'd3
  } err_code_e;

endpackage

// File: rtl/immediate_encode_range_check.sv
// Combinational legality check of an immediate against the decoder's sign/zero extension rules.
module imm_range_check
  import immediate_encode_pkg::*;
(
  input  logic [31:0] i_imm,
  input  logic [2:0]  i_imm_sel,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  logic w_hi20_uni;
  logic w_hi21_uni;
  logic w_hi12_uni;

  // A field is representable only if the bits above it replicate its sign bit.
  assign w_hi20_uni = (&i_imm[31:12]) || !(|i_imm[31:12]);
  assign w_hi21_uni = (&i_imm[31:11]) || !(|i_imm[31:11]);
  assign w_hi12_uni = (&i_imm[31:20]) || !(|i_imm[31:20]);

  always_comb begin
    o_err_code = ERR_NONE;
    case (i_imm_sel)
      IMM_U:          if (i_imm[11:0] != 12'd0) o_err_code = ERR_RANGE;
      IMM_J: begin
        if (i_imm[0])         o_err_code = ERR_ALIGN;
        else if (!w_hi12_uni) o_err_code = ERR_RANGE;
      end
      IMM_B: begin
        if (i_imm[0])         o_err_code = ERR_ALIGN;
        else if (!w_hi20_uni) o_err_code = ERR_RANGE;
      end
      IMM_S, IMM_I_SIGNED: if (!w_hi21_uni) o_err_code = ERR_RANGE;
      IMM_I_UNSIGNED: if (i_imm[31:12] != 20'd0) o_err_code = ERR_RANGE;
      IMM_I_SHIFT:    if (i_imm[31:5] != 27'd0) o_err_code = ERR_RANGE;
      default:        o_err_code = ERR_SEL;
    endcase
  end

  assign o_err = (o_err_code != ERR_NONE);

endmodule

// File: rtl/immediate_encode.sv
// Two-stage packer scattering an immediate into instruction[31:7], with legality
// checking and a saturating count of errored beats delivered downstream.
module immediate_encode
  import immediate_encode_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IMM,
  input  logic [2:0]       IMM_SEL,
  input  logic [24:0]      FIELDS,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [24:0]      OUT,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic [CNT_W-1:0] ERR_COUNT,
  input  logic             CLR_CNT
);

  logic             r_s1_valid;
  logic [31:0]      r_s1_imm;
  logic [2:0]       r_s1_sel;
  logic [24:0]      r_s1_fields;
  logic             r_out_valid;
  logic [24:0]      r_out;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_err_count;

  logic             w_s2_free;
  logic             w_err;
  logic [1:0]       w_err_code;
  logic [24:0]      w_packed;

  assign w_s2_free = !r_out_valid || OUT_READY;
  assign IN_READY  = !r_s1_valid || w_s2_free;

  imm_range_check u_check (
    .i_imm      (r_s1_imm),
    .i_imm_sel  (r_s1_sel),
    .o_err      (w_err),
    .o_err_code (w_err_code)
  );

  // Bits outside the immediate's positions pass through from FIELDS.
  always_comb begin
    w_packed = r_s1_fields;
    case (r_s1_sel)
      IMM_U: w_packed[24:5] = r_s1_imm[31:12];
      IMM_J: begin
        w_packed[24]    = r_s1_imm[20];
        w_packed[23:14] = r_s1_imm[10:1];
        w_packed[13]    = r_s1_imm[11];
        w_packed[12:5]  = r_s1_imm[19:12];
      end
      IMM_B: begin
        w_packed[24]    = r_s1_imm[12];
        w_packed[23:18] = r_s1_imm[10:5];
        w_packed[4:1]   = r_s1_imm[4:1];
        w_packed[0]     = r_s1_imm[11];
      end
      IMM_S: begin
        w_packed[24:18] = r_s1_imm[11:5];
        w_packed[4:0]   = r_s1_imm[4:0];
      end
      IMM_I_SIGNED, IMM_I_UNSIGNED: w_packed[24:13] = r_s1_imm[11:0];
      IMM_I_SHIFT:  w_packed[17:13] = r_s1_imm[4:0];
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_s1_valid  <= 1'b0;
      r_s1_imm    <= '0;
      r_s1_sel    <= '0;
      r_s1_fields <= '0;
    end else if (IN_READY) begin
      r_s1_valid <= IN_VALID;
      if (IN_VALID) begin
        r_s1_imm    <= IMM;
        r_s1_sel    <= IMM_SEL;
        r_s1_fields <= FIELDS;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else if (w_s2_free) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out      <= w_packed;
        r_err      <= w_err;
        r_err_code <= w_err_code;
      end
    end
  end

  // Clear takes precedence over a coincident increment.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_err_count <= '0;
    end else if (CLR_CNT) begin
      r_err_count <= '0;
    end else if (r_out_valid && OUT_READY && r_err && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign OUT_VALID = r_out_valid;
  assign OUT       = r_out;
  assign ERR       = r_err;
  assign ERR_CODE  = r_err_code;
  assign ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_immediate_encode.sv
// Directed bench for immediate_encode: packing, checks, backpressure, counter and reset.
module tb_immediate_encode;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IMM;
  logic [2:0]  IMM_SEL;
  logic [24:0] FIELDS;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [24:0] OUT;
  logic        ERR;
  logic [1:0]  ERR_CODE;
  logic [7:0]  ERR_COUNT;
  logic        CLR_CNT;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  immediate_encode #(.CNT_W(8)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IMM       (IMM),
    .IMM_SEL   (IMM_SEL),
    .FIELDS    (FIELDS),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .ERR       (ERR),
    .ERR_CODE  (ERR_CODE),
    .ERR_COUNT (ERR_COUNT),
    .CLR_CNT   (CLR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_one(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                          input logic [24:0] fields, input logic [24:0] exp_out,
                          input logic exp_err, input logic [1:0] exp_code);
    @(negedge CLK);
    IN_VALID = 1'b1; IMM_SEL = sel; IMM = imm; FIELDS = fields;
    check({tag, "/in_ready"}, 32'(IN_READY), 32'd1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    check({tag, "/early_valid"}, 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    check({tag, "/out_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "/out"}, 32'(OUT), 32'(exp_out));
    check({tag, "/err"}, 32'(ERR), 32'(exp_err));
    check({tag, "/err_code"}, 32'(ERR_CODE), 32'(exp_code));
    if (exp_err) exp_cnt++;
    @(negedge CLK);
    check({tag, "/err_count"}, 32'(ERR_COUNT), 32'(exp_cnt));
  endtask

  initial begin
    RESETN = 1'b0; IN_VALID = 1'b0; IMM = '0; IMM_SEL = '0; FIELDS = '0;
    OUT_READY = 1'b1; CLR_CNT = 1'b0;
    #12;
    check("rst/out_valid", 32'(OUT_VALID), 32'd0);
    check("rst/out", 32'(OUT), 32'd0);
    check("rst/err", 32'(ERR), 32'd0);
    check("rst/err_code", 32'(ERR_CODE), 32'd0);
    check("rst/err_count", 32'(ERR_COUNT), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    #1 check("rst/in_ready", 32'(IN_READY), 32'd1);

    // sel codes: 0 I_SIGNED, 1 I_UNSIGNED, 2 I_SHIFT, 3 S, 4 B, 5 U, 6 J, 7 unused
    send_one("i_neg",      3'd0, 32'hFFFFF800, 25'h0,       25'h1000000, 1'b0, 2'd0);
    send_one("j_misalign", 3'd6, 32'h00000801, 25'h0,       25'h0002000, 1'b1, 2'd2);
    send_one("b_range",    3'd4, 32'h00001000, 25'h0,       25'h1000000, 1'b1, 2'd1);
    send_one("b_neg",      3'd4, 32'hFFFFF000, 25'h0,       25'h1000000, 1'b0, 2'd0);
    send_one("u_ok",       3'd5, 32'h12345000, 25'h1F,      25'h02468BF, 1'b0, 2'd0);
    send_one("u_range",    3'd5, 32'h12345001, 25'h0,       25'h02468A0, 1'b1, 2'd1);
    send_one("s_neg1",     3'd3, 32'hFFFFFFFF, 25'h0,       25'h1FC001F, 1'b0, 2'd0);
    send_one("shift_ok",   3'd2, 32'h00000005, 25'h0800000, 25'h080A000, 1'b0, 2'd0);
    send_one("shift_rng",  3'd2, 32'h00000020, 25'h0,       25'h0000000, 1'b1, 2'd1);
    send_one("iu_ok",      3'd1, 32'h00000FFF, 25'h0,       25'h1FFE000, 1'b0, 2'd0);
    send_one("iu_range",   3'd1, 32'h00001000, 25'h0,       25'h0000000, 1'b1, 2'd1);
    send_one("j_neg",      3'd6, 32'hFFF00000, 25'h0,       25'h1000000, 1'b0, 2'd0);
    send_one("j_pos",      3'd6, 32'h000FFFFE, 25'h0,       25'h0FFFFE0, 1'b0, 2'd0);
    send_one("j_range",    3'd6, 32'h00100000, 25'h0,       25'h1000000, 1'b1, 2'd1);
    send_one("s_range",    3'd3, 32'h00000800, 25'h0,       25'h1000000, 1'b1, 2'd1);
    send_one("sel_bad",    3'd7, 32'h00000123, 25'h1ABCDEF, 25'h1ABCDEF, 1'b1, 2'd3);
    send_one("b_align_pri",3'd4, 32'h00001001, 25'h0,       25'h1000000, 1'b1, 2'd2);

    // Backpressure: two beats held, then drain in order.
    OUT_READY = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b1; IMM_SEL = 3'd5; FIELDS = '0; IMM = 32'h00001000;
    @(negedge CLK);
    IMM = 32'h00002000;
    @(negedge CLK);
    check("bp/ready_fall", 32'(IN_READY), 32'd0);
    check("bp/valid_s0", 32'(OUT_VALID), 32'd1);
    check("bp/out_s0", 32'(OUT), 32'h20);
    IMM = 32'h00003000;
    @(negedge CLK);
    check("bp/ready_s1", 32'(IN_READY), 32'd0);
    check("bp/out_s1", 32'(OUT), 32'h20);
    @(negedge CLK);
    check("bp/ready_s2", 32'(IN_READY), 32'd0);
    check("bp/out_s2", 32'(OUT), 32'h20);
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp/out_b1", 32'(OUT), 32'h40);
    IMM = 32'h00004000;
    @(negedge CLK);
    check("bp/out_b2", 32'(OUT), 32'h60);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("bp/out_b3", 32'(OUT), 32'h80);
    check("bp/valid_b3", 32'(OUT_VALID), 32'd1);
    @(negedge CLK);
    check("bp/drained", 32'(OUT_VALID), 32'd0);
    check("bp/err_count", 32'(ERR_COUNT), 32'(exp_cnt));

    // Counter clear, then saturation over 300 errored beats.
    CLR_CNT = 1'b1;
    @(negedge CLK);
    CLR_CNT = 1'b0;
    check("cnt/cleared", 32'(ERR_COUNT), 32'd0);
    IN_VALID = 1'b1; IMM_SEL = 3'd7; FIELDS = 25'h1ABCDEF;
    for (int i = 0; i < 300; i++) @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("cnt/saturate", 32'(ERR_COUNT), 32'd255);

    // Clear coinciding with an errored handshake.
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("clr/valid", 32'(OUT_VALID), 32'd1);
    CLR_CNT = 1'b1;
    @(negedge CLK);
    CLR_CNT = 1'b0;
    check("clr/wins", 32'(ERR_COUNT), 32'd0);
    exp_cnt = 0;
    send_one("cnt_inc", 3'd7, 32'h0, 25'h0000055, 25'h0000055, 1'b1, 2'd3);

    // Asynchronous reset with two beats in flight.
    @(negedge CLK);
    IN_VALID = 1'b1; IMM_SEL = 3'd7; FIELDS = 25'h0000011;
    @(negedge CLK);
    FIELDS = 25'h0000022;
    @(negedge CLK);
    check("mid/valid_pre", 32'(OUT_VALID), 32'd1);
    #1 RESETN = 1'b0;
    IN_VALID = 1'b0;
    #1;
    check("mid/valid", 32'(OUT_VALID), 32'd0);
    check("mid/out", 32'(OUT), 32'd0);
    check("mid/err", 32'(ERR), 32'd0);
    check("mid/err_count", 32'(ERR_COUNT), 32'd0);
    #1 RESETN = 1'b1;
    @(negedge CLK);
    check("mid/in_ready", 32'(IN_READY), 32'd1);
    check("mid/no_stale", 32'(OUT_VALID), 32'd0);
    exp_cnt = 0;
    send_one("post_rst", 3'd5, 32'hABCDE000, 25'h0, 25'h1579BC0, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
